// File: rtl/ts_packet_arbiter.sv
// Packet-level arbiter: grants whole TS packets round-robin or by fixed priority and
// serialises them onto one registered byte stream. Define NULL_INSERT_EN to fill idle slots with null packets.
module ts_packet_arbiter #(
    parameter int N_CH    = 4,
    parameter int PKT_LEN = 188,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic                SYS_CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     GOT_FULL_PACKET,
    input  logic [8*N_CH-1:0]   DATA_IN,
    input  logic [N_CH-1:0]     CH_EN,
    input  logic                MODE,
    input  logic                OUT_READY,
    output logic [N_CH-1:0]     GIVE_ME_ONE_PACKET,
    output logic [7:0]          DATA_OUT,
    output logic                D_VALID_OUT,
    output logic                P_SYNC_OUT,
    output logic [CH_W-1:0]     CUR_CH,
    output logic                NULL_ACTIVE,
    output logic                SYNC_ERR
);

    localparam int CNT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);
    localparam logic [CH_W:0]    NCH  = (CH_W + 1)'(N_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
`ifdef NULL_INSERT_EN
        S_STREAM,
        S_NULL
`else
        S_STREAM
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             psync_q, psync_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic             serr_q, serr_d;
`ifdef NULL_INSERT_EN
    logic             null_q, null_d;
`endif

    logic [N_CH-1:0]  cand;
    logic [N_CH-1:0]  rot;
    logic [CH_W:0]    rr_sum;
    logic [CH_W-1:0]  rr_grant;
    logic [CH_W-1:0]  pr_grant;
    logic [CH_W-1:0]  sel;
    logic [CH_W:0]    sel_inc;
    logic [CH_W-1:0]  ptr_nxt;
    logic [7:0]       src_byte;

    function automatic logic [CH_W-1:0] first_set(input logic [N_CH-1:0] v);
        logic found;
        found     = 1'b0;
        first_set = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && v[i]) begin
                found     = 1'b1;
                first_set = CH_W'(i);
            end
        end
    endfunction

`ifdef NULL_INSERT_EN
    function automatic logic [7:0] null_byte(input logic [CNT_W-1:0] k);
        logic [7:0] b;
        b = 8'hFF;
        if (k == CNT_W'(0))      b = 8'h47;
        else if (k == CNT_W'(1)) b = 8'h1F;
        else if (k == CNT_W'(3)) b = 8'h10;
        return b;
    endfunction
`endif

    assign cand     = GOT_FULL_PACKET & CH_EN;
    assign src_byte = DATA_IN[8*grant_q +: 8];

    // Round-robin: rotate candidates so ptr lands at bit 0, take the lowest set bit, undo the rotation.
    always_comb begin
        rot      = N_CH'({cand, cand} >> ptr_q);
        rr_sum   = {1'b0, ptr_q} + {1'b0, first_set(rot)};
        rr_grant = CH_W'((rr_sum >= NCH) ? rr_sum - NCH : rr_sum);
        pr_grant = first_set(cand);
        sel      = MODE ? pr_grant : rr_grant;
        sel_inc  = {1'b0, sel} + 1'b1;
        ptr_nxt  = CH_W'((sel_inc == NCH) ? '0 : sel_inc);
    end

    always_comb begin
        GIVE_ME_ONE_PACKET = '0;
        if (state_q == S_REQ) GIVE_ME_ONE_PACKET[grant_q] = 1'b1;
    end

    // The output register is loaded one cycle ahead of the byte it shows; cnt is the index on DATA_OUT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        psync_d  = 1'b0;
        cur_ch_d = cur_ch_q;
        serr_d   = 1'b0;
`ifdef NULL_INSERT_EN
        null_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (OUT_READY && (cand != '0)) begin
                    state_d = S_REQ;
                    grant_d = sel;
                    if (!MODE) ptr_d = ptr_nxt;
                end
`ifdef NULL_INSERT_EN
                else if (OUT_READY) begin
                    state_d  = S_NULL;
                    data_d   = null_byte('0);
                    valid_d  = 1'b1;
                    psync_d  = 1'b1;
                    cur_ch_d = '0;
                    null_d   = 1'b1;
                end
`endif
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                state_d  = S_STREAM;
                data_d   = src_byte;
                valid_d  = 1'b1;
                psync_d  = 1'b1;
                cur_ch_d = grant_q;
                serr_d   = (src_byte != 8'h47);
            end
            S_STREAM: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    data_d   = src_byte;
                    valid_d  = 1'b1;
                    cur_ch_d = grant_q;
                end
            end
`ifdef NULL_INSERT_EN
            S_NULL: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    data_d   = null_byte(cnt_q + 1'b1);
                    valid_d  = 1'b1;
                    cur_ch_d = '0;
                    null_d   = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            psync_q  <= 1'b0;
            cur_ch_q <= '0;
            serr_q   <= 1'b0;
`ifdef NULL_INSERT_EN
            null_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            psync_q  <= psync_d;
            cur_ch_q <= cur_ch_d;
            serr_q   <= serr_d;
`ifdef NULL_INSERT_EN
            null_q   <= null_d;
`endif
        end
    end

    assign DATA_OUT    = data_q;
    assign D_VALID_OUT = valid_q;
    assign P_SYNC_OUT  = psync_q;
    assign CUR_CH      = cur_ch_q;
    assign SYNC_ERR    = serr_q;
`ifdef NULL_INSERT_EN
    assign NULL_ACTIVE = null_q;
`else
    assign NULL_ACTIVE = 1'b0;
`endif

endmodule

// File: doc/ts_packet_arbiter.md
# ts_packet_arbiter

Parametrised packet-level arbiter for the pseudo-TS output path. It selects among N_CH reclocked TS sources, each holding complete packets, and requests one whole packet at a time. Requests use the per-channel GIVE_ME_ONE_PACKET / GOT_FULL_PACKET handshake, and arbitration is round-robin or fixed priority. It serialises the packet bytes onto a single byte stream in the SYS_CLK domain, ahead of the output clock-crossing FIFO. Optionally, it fills idle slots with null packets so that downstream rate stays constant.

## Interface
- N_CH, 4: number of source channels (2..16).
- PKT_LEN, 188: bytes per packet (188 or 204).
- CH_W, $clog2(N_CH): channel index width.

Ports:
- SYS_CLK  in  1  the single clock; all logic on its rising edge.
- RST  in  1  reset; synchronous and active-high.
- GOT_FULL_PACKET  in  N_CH  channel i holds at least one complete packet.
- DATA_IN  in  8*N_CH  flattened source bytes; channel i on [8i+7:8i].
- CH_EN  in  N_CH  channel enable mask; a disabled channel is never granted.
- MODE  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- OUT_READY  in  1  downstream can accept a full packet.
- GIVE_ME_ONE_PACKET  out  N_CH  one-cycle one-hot request pulse.
- DATA_OUT  out  8  output byte.
- D_VALID_OUT  out  1  DATA_OUT valid.
- P_SYNC_OUT  out  1  high with byte 0 of each packet.
- CUR_CH  out  CH_W  source of the current byte; meaningful while D_VALID_OUT is high.
- NULL_ACTIVE  out  1  the current packet is an inserted null packet.
- SYNC_ERR  out  1  one-cycle pulse when a granted packet's byte 0 is not 0x47.

## Operation
- FSM states:
  - IDLE → REQ: when OUT_READY=1 and cand = GOT_FULL_PACKET & CH_EN ≠ 0.
  - IDLE → NULL: (macro only) when OUT_READY=1 and cand = 0.
  - REQ → WAIT: always.
  - WAIT → STREAM: always.
  - STREAM → IDLE: after PKT_LEN bytes.
  - NULL → IDLE: after PKT_LEN bytes.
- Grant selection, computed in IDLE:
  - Round-robin searches upward from ptr, wrapping mod N_CH; ptr ← grant+1 (mod N_CH) on each grant.
  - Priority mode uses lowest set bit of cand; ptr unchanged.
- GIVE_ME_ONE_PACKET[grant] is high only in the REQ cycle.
- Once a packet starts, it completes uninterrupted. CH_EN, MODE and OUT_READY changes take effect at the next IDLE decision.
- Source contract: bytes 0..PKT_LEN-1 are presented on DATA_IN on consecutive cycles starting the cycle after the GIVE pulse, with no stalls.
- Byte counter is $clog2(PKT_LEN) bits, 0..PKT_LEN-1; the last byte is at count PKT_LEN-1, and the FSM returns to IDLE with the counter cleared.
- SYNC_ERR: a non-0x47 byte 0 is still forwarded unmodified, with P_SYNC_OUT high.
- GOT_FULL_PACKET of an ungranted channel is ignored; a stale GOT_FULL_PACKET after a grant is the source's responsibility.
- Reset in any state: FSM to IDLE, ptr=0, counter=0. Any packet in flight is dropped and the next packet starts with a fresh request.

## Timing
- Reset values: GIVE_ME_ONE_PACKET=0, DATA_OUT=0x00, D_VALID_OUT=0, P_SYNC_OUT=0, CUR_CH=0, NULL_ACTIVE=0, SYNC_ERR=0.
- GIVE pulse in cycle c:
  - Byte k arrives on DATA_IN in cycle c+1+k.
  - DATA_OUT is registered and shows byte k in cycle c+2+k, with D_VALID_OUT=1.
  - P_SYNC_OUT=1 only at k=0.
  - SYNC_ERR pulses in cycle c+2.
- Latency, IDLE decision to first output byte: 3 cycles.
- Back-to-back packets: D_VALID_OUT is low for exactly 3 cycles between the last byte of one packet and byte 0 of the next.
- Null packet decided in cycle d: bytes appear in cycles d+1..d+PKT_LEN; no idle cycles before the first byte.

## Configuration
- NULL_INSERT_EN defined:
  - The NULL state exists.
  - Null packet bytes are 0x47, 0x1F, 0xFF, 0x10, then 0xFF to PKT_LEN.
  - NULL_ACTIVE=1 and CUR_CH=0 for the whole null packet.
- NULL_INSERT_EN undefined:
  - The FSM stays in IDLE when cand=0, and D_VALID_OUT stays low.
  - NULL_ACTIVE is tied 0.

## Test plan
- Reset mid-STREAM at byte 50 → next cycle all outputs at reset values. After release, with ch2 ready, a fresh GIVE pulse to ch2 and a full PKT_LEN-byte packet.
- N_CH=4, MODE=0, all channels ready continuously → GIVE order 0,1,2,3,0. Each packet has 188 valid bytes, P_SYNC_OUT on the first byte, and exactly 3 invalid cycles between packets.
- MODE=1, channels 1 and 3 ready → channel 1 is always granted. CH_EN=4'b1101 → channel 3 is granted and channel 1 never.
- Channel 0 packet with byte 0 = 0x00 → SYNC_ERR pulses once, 2 cycles after the GIVE pulse, and the packet is forwarded intact.
- NULL_INSERT_EN, cand=0, OUT_READY=1 → 188 bytes 0x47,0x1F,0xFF,0x10,0xFF…, with NULL_ACTIVE=1. Same stimulus with the macro undefined → D_VALID_OUT stays 0.
- OUT_READY=0 with channels ready → no GIVE pulse. OUT_READY dropped mid-packet → the packet still completes.
